// File: rtl/rcon_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : rcon_seq_gen
// Purpose  : Sequential AES round-constant generator. A start request opens a
//            sequence of N round constants (N from key_len). Each next
//            handshake steps forward (xtime) or in reverse (inverse xtime).
// Ports    : clk, rst (sync, active-high)
//            start, dir, key_len  - sequence request, sampled in IDLE
//            next                 - consume current rcon (only when valid)
//            rcon, round_idx      - current constant and its 1-based round
//            valid, last, busy    - sequence status
//            done, err            - one-cycle event pulses
// Config   : RCON_LUT_EN - when defined, rcon comes from a registered
//            10-entry table lookup indexed by the round index instead of
//            the iterative xtime / inverse-xtime register.
// Revision : 1.0 - initial release
// ============================================================================
module rcon_seq_gen #(
  parameter int ROUNDS_128 = 10,
  parameter int ROUNDS_192 = 8,
  parameter int ROUNDS_256 = 7,
  parameter int IDX_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [1:0]       key_len,
  input  logic             next,
  output logic [7:0]       rcon,
  output logic [IDX_W-1:0] round_idx,
  output logic             valid,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_RUN  = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

`ifdef RCON_LUT_EN
  function automatic logic [7:0] f_lut(input logic [IDX_W-1:0] idx);
    logic [7:0] r;
    r = 8'h00;
    case (int'(idx))
      1:  r = 8'h01;
      2:  r = 8'h02;
      3:  r = 8'h04;
      4:  r = 8'h08;
      5:  r = 8'h10;
      6:  r = 8'h20;
      7:  r = 8'h40;
      8:  r = 8'h80;
      9:  r = 8'h1B;
      10: r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction
`else
  function automatic logic [7:0] f_xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
  endfunction

  // Inverse of xtime: undo the conditional 0x1B reduction, then shift right.
  function automatic logic [7:0] f_inv_xtime(input logic [7:0] r);
    return r[0] ? ({1'b0, r[7:1]} ^ 8'h8D) : {1'b0, r[7:1]};
  endfunction

  // xtime^(n-1)(0x01): first constant of a reverse run of length n.
  function automatic logic [7:0] f_pow(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 1; i < n; i++) r = f_xtime(r);
    return r;
  endfunction

  localparam logic [7:0] c_REV_128 = f_pow(ROUNDS_128);
  localparam logic [7:0] c_REV_192 = f_pow(ROUNDS_192);
  localparam logic [7:0] c_REV_256 = f_pow(ROUNDS_256);
`endif

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_dir;
  logic [IDX_W-1:0] r_n;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_rcon;
  logic             r_err;
  logic             w_accept;
  logic             w_step;
  logic             w_last;
  logic [IDX_W-1:0] w_n_sel;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [7:0]       w_rcon_nxt;

  assign w_accept = (r_state == c_ST_IDLE) && start && (key_len != 2'b11);
  assign w_last   = (r_state == c_ST_RUN) &&
                    (r_dir ? (r_idx == IDX_W'(1)) : (r_idx == r_n));
  assign w_step   = (r_state == c_ST_RUN) && next && !w_last;

  always_comb begin
    w_n_sel = IDX_W'(ROUNDS_128);
    case (key_len)
      2'b01:   w_n_sel = IDX_W'(ROUNDS_192);
      2'b10:   w_n_sel = IDX_W'(ROUNDS_256);
      default: w_n_sel = IDX_W'(ROUNDS_128);
    endcase
  end

  // Round index and constant to load on either sequence open or step.
  always_comb begin
    w_idx_nxt  = r_idx;
    w_rcon_nxt = r_rcon;
    if (w_accept) begin
      w_idx_nxt = dir ? w_n_sel : IDX_W'(1);
`ifdef RCON_LUT_EN
      w_rcon_nxt = f_lut(w_idx_nxt);
`else
      w_rcon_nxt = 8'h01;
      if (dir) begin
        case (key_len)
          2'b01:   w_rcon_nxt = c_REV_192;
          2'b10:   w_rcon_nxt = c_REV_256;
          default: w_rcon_nxt = c_REV_128;
        endcase
      end
`endif
    end else if (w_step) begin
      w_idx_nxt = r_dir ? (r_idx - IDX_W'(1)) : (r_idx + IDX_W'(1));
`ifdef RCON_LUT_EN
      w_rcon_nxt = f_lut(w_idx_nxt);
`else
      w_rcon_nxt = r_dir ? f_inv_xtime(r_rcon) : f_xtime(r_rcon);
`endif
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (w_accept) w_state_nxt = c_ST_RUN;
      c_ST_RUN:  if (next && w_last) w_state_nxt = c_ST_DONE;
      c_ST_DONE: w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    valid = (r_state == c_ST_RUN);
    busy  = (r_state == c_ST_RUN) || (r_state == c_ST_DONE);
    done  = (r_state == c_ST_DONE);
    last  = w_last;
  end

  // Sequence datapath and error pulse. A start is rejected either because
  // the key length is illegal (IDLE) or because a sequence is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dir  <= 1'b0;
      r_n    <= '0;
      r_idx  <= '0;
      r_rcon <= 8'h00;
      r_err  <= 1'b0;
    end else begin
      r_err  <= start && ((r_state == c_ST_IDLE) ? (key_len == 2'b11) : 1'b1);
      r_idx  <= w_idx_nxt;
      r_rcon <= w_rcon_nxt;
      if (w_accept) begin
        r_dir <= dir;
        r_n   <= w_n_sel;
      end
    end
  end

  assign rcon      = r_rcon;
  assign round_idx = r_idx;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: doc/rcon_seq_gen.md
# rcon_seq_gen

Sequential AES round-constant generator for the key-expansion datapath. It replaces the per-key-index combinational Rcon lookup with a stepped stream: a start request opens a sequence, and each `next` handshake yields one round constant with its round index. It supports AES-128, AES-192 and AES-256 run lengths at runtime, and can run forward for encryption key expansion or in reverse for on-the-fly decryption key scheduling.

## Interface
Parameters:
- `ROUNDS_128`, default 10: number of round constants emitted for key_len 2'b00.
- `ROUNDS_192`, default 8: number of round constants emitted for key_len 2'b01.
- `ROUNDS_256`, default 7: number of round constants emitted for key_len 2'b10.
- `IDX_W`, default 4: width of `round_idx`; must hold the largest ROUNDS_* value.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new sequence; sampled only in IDLE.
- `dir`  in  1  direction, sampled with start: 0 = forward (01→…), 1 = reverse (last→01).
- `key_len`  in  2  sampled with start: 00 = 128, 01 = 192, 10 = 256, 11 = illegal.
- `next`  in  1  consume current rcon and advance; effective only when `valid`=1.
- `rcon`  out  8  current round constant.
- `round_idx`  out  IDX_W  1-based round number of `rcon`.
- `valid`  out  1  `rcon`/`round_idx` are meaningful.
- `last`  out  1  current `rcon` is the final one of the sequence.
- `busy`  out  1  high in RUN and DONE states.
- `done`  out  1  one-cycle pulse after the final value is consumed.
- `err`  out  1  one-cycle pulse on a rejected request.

## Operation
- State machine: IDLE, RUN, DONE.
- **IDLE**
  - If `start`=1 and `key_len`≠11: latch `dir` and the run length N (ROUNDS_128/192/256), then go to RUN.
  - If `start`=1 and `key_len`=11: pulse `err` and stay in IDLE.
- **Entering RUN**
  - Forward: `rcon`=0x01, `round_idx`=1.
  - Reverse: `rcon`=xtime^(N-1)(0x01), `round_idx`=N. With default parameters this is 0x36 for 128, 0x80 for 192 and 0x40 for 256.
- **RUN**
  - `valid`=1. `last`=1 when `round_idx` equals N (forward) or 1 (reverse).
  - `next`=1 with `last`=0: step once.
    - Forward: rcon ← xtime(rcon) = {rcon[6:0],0} ^ (rcon[7] ? 0x1B : 0); `round_idx`+1.
    - Reverse: rcon ← rcon[0] ? ({1'b0,rcon[7:1]} ^ 0x8D) : {1'b0,rcon[7:1]}; `round_idx`−1.
  - `next`=1 with `last`=1: go to DONE.
  - `next`=0: hold all outputs.
- **DONE**
  - Lasts one cycle: `done`=1, `valid`=0, `last`=0, then return to IDLE.
- **Rejected start**: `start` while `busy`=1 pulses `err`; the state and the sequence are unaffected.
- **Ignored next**: `next` while `valid`=0 has no effect and raises no error.
- **Arithmetic**: all rcon arithmetic is GF(2^8) over the polynomial 0x11B. `round_idx` never wraps; it is bounded by N and 1.

## Timing
- Reset values: `rcon`=0x00, `round_idx`=0, `valid`=0, `last`=0, `busy`=0, `done`=0, `err`=0, state IDLE.
- Start latency: `start` accepted at edge t gives `valid`=1 with the first rcon from t+1.
- Step latency: `next` sampled at edge t gives the new rcon at t+1. Holding `next` high yields one value per cycle, with no bubbles.
- End of sequence: `next` on `last` at edge t gives `done`=1 and `valid`=0 at t+1, and IDLE at t+2. The earliest new `start` is accepted at edge t+2; a `start` at edge t+1 pulses `err`.
- Error timing: `err` is high for exactly one cycle following the offending edge.
- Simultaneous `start` and `next` in RUN: `next` is honoured and `err` pulses.
- Reset mid-operation: `rst` high at any edge forces all reset values at the next cycle. Any in-flight `next` or `start` is discarded.

## Configuration
- Macro `RCON_LUT_EN`:
  - Defined: `rcon` is a registered lookup from a constant 10-entry table {01,02,04,08,10,20,40,80,1B,36} indexed by `round_idx`. The xtime and inverse-xtime logic is not built.
  - Undefined: `rcon` is produced by the iterative xtime / inverse-xtime register described above.
- Both builds give cycle-identical outputs for every legal parameter set with ROUNDS_* ≤ 10. A ROUNDS_* value above 10 is legal only without the macro.

## Test plan
- Forward AES-128: start with key_len=00, dir=0, `next` held high → rcon 01,02,04,08,10,20,40,80,1B,36 on consecutive cycles with `round_idx` 1..10; `last` only with 0x36; `done` pulses one cycle later.
- Reverse AES-256: key_len=10, dir=1 → rcon 40,20,10,08,04,02,01 with `round_idx` 7..1; `last` with 0x01.
- Forward AES-192 with `next` toggled every other cycle → each value is held while `next`=0; the sequence ends at 0x80 with `round_idx`=8.
- Illegal request: key_len=11 with `start` → one-cycle `err`, `valid` stays 0, state stays IDLE. A `start` during RUN → `err` pulse and the sequence continues unchanged.
- Reset mid-sequence at `round_idx`=5 → next cycle all outputs zero. A fresh forward start then gives 0x01 with `round_idx`=1.
- Run all of the above with and without `RCON_LUT_EN` and compare output traces: they must be identical.
